mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit producing the HI and LO registers of the multicycle datapath. Its `hi` and `lo` outputs feed the register-writeback 5-to-1 selector, on the MFHI/MFLO inputs. The control FSM issues `start` with an opcode and two register operands, then stalls on `busy` until `done` pulses. MTHI/MTLO writes are also accepted directly into the HI/LO registers.

## Interface
- `WIDTH`, 32: operand and result width; the unit is verified only at 32.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request an operation; sampled only in IDLE
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `a`  in  32  multiplicand or dividend
- `b`  in  32  multiplier or divisor
- `hi_we`  in  1  MTHI write enable
- `lo_we`  in  1  MTLO write enable
- `wdata`  in  32  MTHI/MTLO data
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `div_zero`  out  1  last division had `b==0`; sticky until the next accepted start

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- **IDLE, `start=1`:**
  - Latch `op`.
  - Latch |a| and |b|. Magnitudes are taken only for signed ops; unsigned ops latch `a` and `b` raw.
  - Latch the result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear the 5-bit iteration counter.
  - Set `busy`, clear `div_zero`, go to MUL or DIV.
- **MUL:** shift-add, one bit per cycle, on a 64-bit accumulator. After 32 iterations go to FIX.
- **DIV:** restoring division, one quotient bit per cycle. After 32 iterations go to FIX.
- **FIX:**
  - Apply sign correction (two's complement of the 64-bit product, the quotient or the remainder, as needed).
  - Write results: MUL gives hi=product[63:32], lo=product[31:0]. DIV gives lo=quotient, hi=remainder.
  - Pulse `done`, clear `busy`, return to IDLE.
- **Arithmetic rules:**
  - Division truncates toward zero. The remainder takes the sign of the dividend.
  - MULT/MULTU give the full 64-bit result, with no overflow.
  - Signed -2^31 / -1: lo=32'h80000000, hi=0. This falls out of the magnitude path plus sign fix and needs no special case.
- **Divide by zero:** the full latency is still taken. In FIX, lo=32'hFFFFFFFF, hi=`a` (the original value), `div_zero`=1.
- **MTHI/MTLO:**
  - A write happens on the next edge when `hi_we`/`lo_we` is high and the FSM is in IDLE and not accepting `start` that cycle.
  - Writes are ignored while `busy`.
  - If `start` and a write enable are both high in IDLE, `start` wins and the write is dropped.
- `start` while busy is ignored; there is no queueing.
- `hi`/`lo` change only in FIX, on MTHI/MTLO writes, or on reset. They hold otherwise, including throughout an operation.

## Timing
- **Reset** (synchronous, overrides everything):
  - State returns to IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0.
  - Counter and accumulators are cleared.
  - Reset mid-operation aborts; no `done` is produced.
- **Latency:** cycle 0 is the cycle `start` is sampled high in IDLE.
  - `busy`=1 in cycles 1–33.
  - `done`=1 in cycle 34 only, with new `hi`/`lo`/`div_zero` valid in that same cycle.
  - Latency is identical for all four ops and for divide-by-zero.
- **Back-to-back:** `start` high during the `done` cycle is accepted, because the FSM is in IDLE. That operation's `done` arrives 34 cycles later.
- **Operand capture:** `a`, `b` and `op` are read only in cycle 0. They may change freely afterwards.
- **MTHI/MTLO:** the written value is visible on `hi`/`lo` the cycle after the write enable.

## Test plan
- Reset, then MULT a=-3 (32'hFFFFFFFD), b=7 -> `done` in cycle 34, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; `busy` high for cycles 1–33 exactly.
- MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Then DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0. Then DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, `div_zero`=1 from cycle 34 until the next start.
- `start` pulsed at cycle 10 of a running MULT, and `lo_we` asserted mid-operation -> both ignored. Start in the `done` cycle -> accepted, second `done` 34 cycles later. `lo_we` with `wdata`=32'hCAFE in IDLE -> lo=32'hCAFE next cycle.
- Assert `reset` at cycle 15 of a DIV -> next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse ever follows.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Shift-add multiply and restoring divide on unsigned magnitudes, with a sign fix-up cycle at the end.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               psign_q, psign_d;
    logic               rsign_q, rsign_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod_neg;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Upper half accumulates the multiplicand; the multiplier drains out of the lower half.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);

    // Partial remainder lives in the upper half, dividend bits shift into it from the lower half.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, mb_q};
    assign rem_sub   = div_trial[WIDTH-1:0] - mb_q;

    assign prod_neg  = -acc_q;

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        psign_d  = psign_q;
        rsign_d  = rsign_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    ma_d     = a_mag;
                    mb_d     = b_mag;
                    psign_d  = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rsign_d  = signed_op & a[WIDTH-1];
                    bzero_d  = (b == '0);
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    state_d  = op[1] ? DIV : MUL;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            DIV: begin
                acc_d = div_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                               : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    if (bzero_q) begin
                        // Rebuild the original dividend from its latched magnitude and sign.
                        lo_d = '1;
                        hi_d = rsign_q ? -ma_q : ma_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = psign_q ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    lo_d = psign_q ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = psign_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            psign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            psign_q  <= psign_d;
            rsign_q  <= rsign_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes model results, a negedge monitor pops on done.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int          checks = 0;
    int          failures = 0;
    logic [64:0] sb[$];
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result as {div_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] p;
        logic [31:0] q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin p = 64'(sx * sy); return {1'b0, p}; end
            2'd1: begin p = {32'h0, x} * {32'h0, y}; return {1'b0, p}; end
            default: begin
                if (y == 32'h0) return {1'b1, x, 32'hFFFFFFFF};
                if (o == 2'd2) begin
                    q = 32'(sx / sy);
                    r = 32'(sx % sy);
                end else begin
                    q = x / y;
                    r = x % y;
                end
                return {1'b0, r, q};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 65'd1, 65'd0);
            end else begin
                chk("result", {div_zero, hi, lo}, sb.pop_front());
            end
        end
    end

    // Caller is at a negedge with the FSM idle; returns at the negedge of the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit inj);
        logic [64:0] e;
        e = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        if (inj) begin hi_we = 1'b1; wdata = 32'h1234; end
        sb.push_back(e);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; hi_we = 1'b0;
                a = $urandom; b = $urandom; op = 2'($urandom);
                chk("dz_clear", div_zero, 0);
            end
            if (inj && k == 10) begin
                start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
            end
            if (inj && k == 11) begin
                start = 1'b0; lo_we = 1'b0;
            end
            chk("busy", busy, (k <= 33));
            chk("done", done, (k == 34));
            if (k == 17) chk("hold", {hi, lo}, {mdl_hi, mdl_lo});
        end
        mdl_hi = e[63:32];
        mdl_lo = e[31:0];
    endtask

    initial begin
        int          ndone;
        logic [1:0]  o;
        logic [31:0] x, y;

        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {hi, lo, busy, done, div_zero}, '0);
        reset = 1'b0;
        @(negedge clk);

        do_op(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
        chk("mult_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_max", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
        do_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        do_op(2'd3, 32'd100, 32'd7, 1'b0);
        chk("divu", {hi, lo}, {32'd2, 32'd14});
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div_ovf", {hi, lo}, {32'd0, 32'h80000000});
        do_op(2'd3, 32'd5, 32'd0, 1'b0);
        chk("divu_zero", {div_zero, hi, lo}, {1'b1, 32'd5, 32'hFFFFFFFF});
        repeat (3) @(negedge clk);
        chk("dz_sticky", div_zero, 1);

        do_op(2'd0, 32'd12345, 32'hFFFF0000, 1'b1);
        do_op(2'd2, 32'h80000000, 32'd0, 1'b0);
        @(negedge clk);

        lo_we = 1'b1; wdata = 32'h0000CAFE;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'h0000CAFE);
        hi_we = 1'b1; wdata = 32'hBEEF0001;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", {hi, lo}, {32'hBEEF0001, 32'h0000CAFE});
        mdl_hi = 32'hBEEF0001; mdl_lo = 32'h0000CAFE;

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op(o, x, y, 1'b0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("reset_abort", {hi, lo, busy, done, div_zero}, '0);
        mdl_hi = '0; mdl_lo = '0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_reset", 65'(ndone), 65'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 65'(sb.size()), 65'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
